// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I instruction-fetch stage. Optional counters: FETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instF,
  output logic [31:0] PCF,
  output logic        validF,
  output logic        fetch_busy,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_inst;
  logic [31:0] r_pcout;
  logic        r_squash;
  logic        r_valid;
  logic [31:0] w_target;

  assign w_target = redirect_pc & ~32'd3;

  // r_req_addr is separate from r_pc so a redirect never disturbs a request
  // that is still waiting for imem_req_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_inst     <= NOP_INST;
      r_pcout    <= 32'h0;
      r_squash   <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      if (redirect) begin
        r_pc <= w_target;
      end
      case (r_state)
        S_REQ: begin
          if (redirect) begin
            r_squash <= 1'b1;
          end
          if (imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_squash || redirect) begin
              r_squash   <= 1'b0;
              r_state    <= S_REQ;
              r_req_addr <= redirect ? w_target : r_pc;
            end else begin
              r_inst  <= imem_rsp_data;
              r_pcout <= r_pc;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end else if (redirect) begin
            r_squash <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_req_addr <= w_target;
            r_state    <= S_REQ;
          end else if (!stallF) begin
            r_pc       <= r_pc + 32'd4;
            r_req_addr <= r_pc + 32'd4;
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ) && reset;
  assign imem_req_addr  = r_req_addr;
  assign instF          = r_inst;
  assign PCF            = r_pcout;
  assign validF         = r_valid;
  assign fetch_busy     = ~r_valid;

`ifdef FETCH_PERF_EN
  logic        w_consume;
  logic        w_discard;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;

  assign w_consume = (r_state == S_HOLD) && !stallF && !redirect;
  assign w_discard = (r_state == S_WAIT) && imem_rsp_valid && (r_squash || redirect);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt  <= 32'h0;
      r_squash_cnt <= 32'h0;
    end else begin
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_discard) begin
        r_squash_cnt <= r_squash_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign squash_cnt = r_squash_cnt;
`else
  assign fetch_cnt  = 32'h0;
  assign squash_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: directed scenarios plus randomized run against a
// transaction-level reference model and a simple instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] instF;
  logic [31:0] PCF;
  logic        validF;
  logic        fetch_busy;
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;

  fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instF(instF), .PCF(PCF), .validF(validF), .fetch_busy(fetch_busy),
    .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instruction memory: word at address a is a ^ MAGIC
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          mem_lat = 0;
  bit          mem_rand = 1'b0;

  // reference model: architectural next-fetch PC plus one-request bookkeeping
  bit          m_hold, m_out, m_drop;
  logic [31:0] m_pc, m_pres, m_inst, m_ipc, m_fetch, m_squash;

  task automatic model_reset();
    m_hold = 0; m_out = 0; m_drop = 0;
    m_pc = RPC; m_pres = RPC; m_inst = NOP; m_ipc = 32'h0;
    m_fetch = 32'h0; m_squash = 32'h0;
    mem_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance model and memory, return at negedge.
  task automatic tick(input logic r, input logic [31:0] tgt, input logic s, input logic rdy);
    logic        acc, rv;
    logic [31:0] rd, a;
    redirect = r; redirect_pc = tgt; stallF = s; imem_req_ready = rdy;
    rv = 1'b0; rd = 32'h0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        rv = 1'b1; rd = mem_addr ^ MAGIC; mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? rd : $urandom;
    #1;
    acc = imem_req_valid && rdy;
    a   = imem_req_addr;
    if (reset) begin
      if (m_hold) begin
        if (r) begin
          m_hold = 0; m_pc = tgt & ~32'd3; m_pres = m_pc; m_inst = NOP;
        end else if (!s) begin
          m_hold = 0; m_fetch++; m_pc = m_pc + 32'd4; m_pres = m_pc; m_inst = NOP;
        end
      end else if (m_out) begin
        if (rv) begin
          m_out = 0;
          if (m_drop || r) begin
            m_squash++; m_drop = 0;
            if (r) m_pc = tgt & ~32'd3;
            m_pres = m_pc;
          end else begin
            m_hold = 1; m_inst = rd; m_ipc = m_pc;
          end
        end else if (r) begin
          m_drop = 1; m_pc = tgt & ~32'd3;
        end
      end else begin
        if (r) begin
          m_drop = 1; m_pc = tgt & ~32'd3;
        end
        if (rdy) m_out = 1;
      end
    end
    @(posedge clk);
    if (acc) begin
      mem_pend = 1'b1; mem_addr = a;
      mem_cnt  = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RPC) begin n_bad++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RPC); end
    n_cmp++; if (instF !== NOP) begin n_bad++; $display("FAIL reset_instF: got %h want %h", instF, NOP); end
    n_cmp++; if (PCF !== 32'h0) begin n_bad++; $display("FAIL reset_PCF: got %h want 0", PCF); end
    n_cmp++; if (validF !== 1'b0) begin n_bad++; $display("FAIL reset_validF: got %b want 0", validF); end
    n_cmp++; if (fetch_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", fetch_busy); end
    n_cmp++; if (fetch_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_fetch_cnt: got %h want 0", fetch_cnt); end
    n_cmp++; if (squash_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_squash_cnt: got %h want 0", squash_cnt); end
  endtask

  task automatic test_zero_wait();
    logic        ev;
    logic [31:0] ep;
    mem_lat = 0;
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin n_bad++; $display("FAIL first_req: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RPC); end
    for (int i = 0; i < 8; i++) begin
      ev = ((i % 3) == 2);
      ep = 32'(4 * (i / 3));
      n_cmp++; if (validF !== ev) begin n_bad++; $display("FAIL zw_validF[%0d]: got %b want %b", i, validF, ev); end
      if (ev) begin
        n_cmp++; if (PCF !== ep) begin n_bad++; $display("FAIL zw_PCF[%0d]: got %h want %h", i, PCF, ep); end
        n_cmp++; if (instF !== (ep ^ MAGIC)) begin n_bad++; $display("FAIL zw_instF[%0d]: got %h want %h", i, instF, ep ^ MAGIC); end
      end
      tick(0, 0, 0, 1);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (validF !== 1'b1 || PCF !== 32'h8) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=8", k, validF, PCF); end
      n_cmp++; if (instF !== (32'h8 ^ MAGIC)) begin n_bad++; $display("FAIL stall_instF[%0d]: got %h want %h", k, instF, 32'h8 ^ MAGIC); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_noreq[%0d]: got %b want 0", k, imem_req_valid); end
      tick(0, 0, 1, 1);
    end
    tick(0, 0, 0, 1);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin n_bad++; $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=0000000c", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] es;
    mem_lat = 2;
    tick(0, 0, 0, 1);
    tick(1, 32'h100, 0, 1);
    for (int k = 0; k < 8; k++) begin
      if (imem_req_valid) break;
      n_cmp++; if (validF !== 1'b0) begin n_bad++; $display("FAIL rw_validF[%0d]: got %b want 0", k, validF); end
      tick(0, 0, 0, 1);
    end
    es = PERF ? 32'd1 : 32'd0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rw_next_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    n_cmp++; if (squash_cnt !== es) begin n_bad++; $display("FAIL rw_squash_cnt: got %h want %h", squash_cnt, es); end
  endtask

  task automatic test_redirect_req();
    logic [31:0] es;
    mem_lat = 0;
    tick(1, 32'h203, 0, 0);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rr_hold1: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    tick(0, 0, 0, 0);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rr_hold2: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
    tick(0, 0, 0, 1);
    n_cmp++; if (validF !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rr_wait: got v=%b req=%b want 0 0", validF, imem_req_valid); end
    tick(0, 0, 0, 1);
    es = PERF ? 32'd2 : 32'd0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL rr_next_req: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
    n_cmp++; if (validF !== 1'b0) begin n_bad++; $display("FAIL rr_validF: got %b want 0", validF); end
    n_cmp++; if (squash_cnt !== es) begin n_bad++; $display("FAIL rr_squash_cnt: got %h want %h", squash_cnt, es); end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] ef;
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    n_cmp++; if (validF !== 1'b1 || PCF !== 32'h200) begin n_bad++; $display("FAIL rh_hold: got v=%b pc=%h want v=1 pc=00000200", validF, PCF); end
    n_cmp++; if (instF !== (32'h200 ^ MAGIC)) begin n_bad++; $display("FAIL rh_instF: got %h want %h", instF, 32'h200 ^ MAGIC); end
    tick(1, 32'h400, 1, 1);
    ef = PERF ? 32'd3 : 32'd0;
    n_cmp++; if (validF !== 1'b0 || instF !== NOP) begin n_bad++; $display("FAIL rh_drop: got v=%b inst=%h want v=0 inst=%h", validF, instF, NOP); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin n_bad++; $display("FAIL rh_next_req: got v=%b a=%h want v=1 a=00000400", imem_req_valid, imem_req_addr); end
    n_cmp++; if (fetch_cnt !== ef) begin n_bad++; $display("FAIL rh_fetch_cnt: got %h want %h", fetch_cnt, ef); end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC) begin n_bad++; $display("FAIL rm_req: got v=%b a=%h want v=0 a=%h", imem_req_valid, imem_req_addr, RPC); end
    n_cmp++; if (validF !== 1'b0 || fetch_busy !== 1'b1) begin n_bad++; $display("FAIL rm_valid: got v=%b busy=%b want 0 1", validF, fetch_busy); end
    n_cmp++; if (instF !== NOP || PCF !== 32'h0) begin n_bad++; $display("FAIL rm_out: got inst=%h pc=%h want %h 0", instF, PCF, NOP); end
    n_cmp++; if (fetch_cnt !== 32'h0 || squash_cnt !== 32'h0) begin n_bad++; $display("FAIL rm_cnt: got %h %h want 0 0", fetch_cnt, squash_cnt); end
    model_reset();
    @(negedge clk);
    tick(0, 0, 0, 1);
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin n_bad++; $display("FAIL rm_first_req: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RPC); end
  endtask

  task automatic test_random();
    logic [31:0] ef, es;
    mem_rand = 1'b1;
    for (int c = 0; c < 600; c++) begin
      ef = PERF ? m_fetch : 32'h0;
      es = PERF ? m_squash : 32'h0;
      n_cmp++; if (imem_req_valid !== (!m_hold && !m_out)) begin n_bad++; $display("FAIL rnd_req_valid[%0d]: got %b want %b", c, imem_req_valid, !m_hold && !m_out); end
      if (!m_hold && !m_out) begin
        n_cmp++; if (imem_req_addr !== m_pres) begin n_bad++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", c, imem_req_addr, m_pres); end
      end
      n_cmp++; if (validF !== m_hold) begin n_bad++; $display("FAIL rnd_validF[%0d]: got %b want %b", c, validF, m_hold); end
      n_cmp++; if (fetch_busy !== !m_hold) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, fetch_busy, !m_hold); end
      n_cmp++; if (instF !== m_inst) begin n_bad++; $display("FAIL rnd_instF[%0d]: got %h want %h", c, instF, m_inst); end
      if (m_hold) begin
        n_cmp++; if (PCF !== m_ipc) begin n_bad++; $display("FAIL rnd_PCF[%0d]: got %h want %h", c, PCF, m_ipc); end
      end
      n_cmp++; if (fetch_cnt !== ef) begin n_bad++; $display("FAIL rnd_fetch_cnt[%0d]: got %h want %h", c, fetch_cnt, ef); end
      n_cmp++; if (squash_cnt !== es) begin n_bad++; $display("FAIL rnd_squash_cnt[%0d]: got %h want %h", c, squash_cnt, es); end
      tick(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
